// File: rtl/rom_sched_pkg.sv
// ---------------------------------------------------------------------------
// rom_sched_pkg
//   Shared types and constants for the ROM fetch scheduler.
//   - mode_t           : scheduler state, encoded so it doubles as cur_mode
//   - *_DEF constants  : default ROM region layout (routine / OS / programs)
//   - offw(), idxw()   : width helpers for region offsets and indices
// ---------------------------------------------------------------------------
package rom_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CTX  = 2'd1,
        S_OS   = 2'd2,
        S_PROG = 2'd3
    } mode_t;

    localparam int REGION_SIZE_DEF  = 200;
    localparam int ROUTINE_BASE_DEF = 0;
    localparam int OS_BASE_DEF      = 200;
    localparam int PROG_BASE_DEF    = 400;

    // Width of an offset inside one region.
    function automatic int offw(input int region_size);
        return (region_size > 1) ? $clog2(region_size) : 1;
    endfunction

    // Width of an index over n items, never narrower than one bit.
    function automatic int idxw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rom_fetch_scheduler_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin selector. Starting just after 'last' and
//   wrapping around (with 'last' itself considered last), returns the first
//   index whose mask bit is clear.
//
// Ports
//   mask   in  [NUM]  1 = entry unavailable (halted)
//   last   in  [IW]   most recently selected index
//   index  out [IW]   selected index (valid when found=1)
//   found  out        at least one entry was available
// ---------------------------------------------------------------------------
module rr_picker #(
    parameter int NUM = 2,
    parameter int IW  = 1
) (
    input  logic [NUM-1:0] mask,
    input  logic [IW-1:0]  last,
    output logic [IW-1:0]  index,
    output logic           found
);

    // Two ascending passes: first the entries above 'last', then the wrap
    // region 0..last. The first free entry seen is the round-robin winner.
    always_comb begin
        // NOTE: every output gets a default before any conditional logic, so
        // no path leaves it unassigned and no latch is inferred.
        index = last;
        found = 1'b0;
        for (int j = 0; j < NUM; j++) begin
            if (!found && !mask[j] && (j > int'(last))) begin
                index = IW'(j);
                found = 1'b1;
            end
        end
        for (int j = 0; j < NUM; j++) begin
            if (!found && !mask[j] && (j <= int'(last))) begin
                index = IW'(j);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rom_fetch_scheduler.sv
// ---------------------------------------------------------------------------
// rom_fetch_scheduler
//   Fetch sequencer and time-slice scheduler in front of a synchronous
//   instruction ROM with one cycle of read latency. The ROM is divided into
//   a context-switch routine region, an OS region and one region per user
//   program. User programs are preempted round-robin after QUANTUM enabled
//   fetch cycles, and each keeps a saved PC across preemptions.
//
// Optional build macro
//   SCHED_STATS_EN : adds issued_count, one saturating 32-bit counter per
//                    program counting valid instructions issued to it.
//
// Ports
//   clk            in   clock
//   rst_n          in   asynchronous active-low reset
//   enable         in   fetch advance (0 = stall)
//   branch_valid   in   redirect within the current program region
//   branch_target  in   redirect offset
//   halt           in   current user program finished
//   yield          in   OS requests a dispatch (used only in S_OS)
//   ctx_done       in   switch routine finished (used only in S_CTX)
//   rom_addr       out  ROM word address = region base + pc
//   instr_valid    out  ROM q this cycle is a valid instruction
//   cur_mode       out  0 idle / 1 ctx / 2 os / 3 prog
//   cur_prog       out  running (or most recently run) program id
//   ctx_switch     out  one-cycle pulse on preemption or halt
//   all_done       out  every program has halted
//   issued_count   out  per-program issue counters (SCHED_STATS_EN only)
// ---------------------------------------------------------------------------
module rom_fetch_scheduler
    import rom_sched_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int REGION_SIZE  = REGION_SIZE_DEF,
    parameter int ROUTINE_BASE = ROUTINE_BASE_DEF,
    parameter int OS_BASE      = OS_BASE_DEF,
    parameter int PROG_BASE    = PROG_BASE_DEF,
    parameter int NUM_PROGS    = 2,
    parameter int QUANTUM      = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             enable,
    input  logic                             branch_valid,
    input  logic [offw(REGION_SIZE)-1:0]     branch_target,
    input  logic                             halt,
    input  logic                             yield,
    input  logic                             ctx_done,
    output logic [ADDR_WIDTH-1:0]            rom_addr,
    output logic                             instr_valid,
    output logic [1:0]                       cur_mode,
    output logic [idxw(NUM_PROGS)-1:0]       cur_prog,
    output logic                             ctx_switch,
    output logic                             all_done
`ifdef SCHED_STATS_EN
    ,
    output logic [NUM_PROGS*32-1:0]          issued_count
`endif
);

    localparam int OFFW = offw(REGION_SIZE);
    localparam int PW   = idxw(NUM_PROGS);
    localparam int QW   = idxw(QUANTUM);

    localparam logic [OFFW-1:0] PC_LAST = OFFW'(REGION_SIZE - 1);
    localparam logic [QW-1:0]   Q_LAST  = QW'(QUANTUM - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    mode_t                state;
    logic [OFFW-1:0]      pc;
    logic [OFFW-1:0]      saved_pc [NUM_PROGS];
    logic [NUM_PROGS-1:0] halted;
    logic [QW-1:0]        qcnt;

    // -----------------------------------------------------------------------
    // Next-program selection
    // -----------------------------------------------------------------------
    logic [PW-1:0] pick_idx;
    logic          pick_found;

    rr_picker #(
        .NUM (NUM_PROGS),
        .IW  (PW)
    ) u_rr_picker (
        .mask  (halted),
        .last  (cur_prog),
        .index (pick_idx),
        .found (pick_found)
    );

    // -----------------------------------------------------------------------
    // Next-pc candidates
    // -----------------------------------------------------------------------
    logic [OFFW-1:0] pc_adv;     // sequential advance, honouring stall
    logic [OFFW-1:0] prog_pc;    // program pc after optional redirect
    logic            slice_end;  // program leaves S_PROG this cycle

    always_comb begin
        pc_adv    = pc;
        prog_pc   = pc;
        slice_end = 1'b0;
        if (enable) begin
            pc_adv = (pc == PC_LAST) ? '0 : pc + OFFW'(1);
        end
        // A redirect overrides the sequential advance. When it coincides with
        // preemption, this is also the PC the program resumes at.
        prog_pc   = branch_valid ? branch_target : pc_adv;
        slice_end = halt || (enable && (qcnt == Q_LAST));
    end

    // -----------------------------------------------------------------------
    // Scheduler FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_OS;
            pc          <= '0;
            halted      <= '0;
            qcnt        <= '0;
            cur_prog    <= '0;
            instr_valid <= 1'b0;
            ctx_switch  <= 1'b0;
            all_done    <= 1'b0;
            // NOTE: the saved-PC table is a handful of flops, not a RAM, and a
            // reset must make every program restart at offset 0, so it is
            // cleared here along with the rest of the state.
            for (int i = 0; i < NUM_PROGS; i++) begin
                saved_pc[i] <= '0;
            end
        end else begin
            // NOTE: state is updated with non-blocking assignments only, so
            // every branch below sees the pre-edge values of all registers.
            instr_valid <= 1'b0;
            ctx_switch  <= 1'b0;

            case (state)
                S_OS: begin
                    if (yield) begin
                        if (pick_found) begin
                            state    <= S_PROG;
                            cur_prog <= pick_idx;
                            pc       <= saved_pc[pick_idx];
                            qcnt     <= '0;
                        end else begin
                            state    <= S_IDLE;
                            pc       <= '0;
                            all_done <= 1'b1;
                        end
                    end else begin
                        pc          <= pc_adv;
                        instr_valid <= enable;
                    end
                end

                S_PROG: begin
                    if (slice_end) begin
                        // Halt and quantum expiry share one path; halt just
                        // additionally retires the program.
                        saved_pc[cur_prog] <= prog_pc;
                        if (halt) begin
                            halted[cur_prog] <= 1'b1;
                        end
                        state      <= S_CTX;
                        pc         <= '0;
                        qcnt       <= '0;
                        ctx_switch <= 1'b1;
                    end else begin
                        pc          <= prog_pc;
                        instr_valid <= enable && !branch_valid;
                        if (enable) begin
                            qcnt <= qcnt + QW'(1);
                        end
                    end
                end

                S_CTX: begin
                    if (ctx_done) begin
                        state <= S_OS;
                        pc    <= '0;
                    end else begin
                        pc          <= pc_adv;
                        instr_valid <= enable;
                    end
                end

                default: begin
                    // S_IDLE is terminal until reset; park at the OS base.
                    pc <= '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // ROM address: region base of the current state plus the pc
    // -----------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] region_base;

    always_comb begin
        case (state)
            S_CTX:   region_base = ADDR_WIDTH'(ROUTINE_BASE);
            S_PROG:  region_base = ADDR_WIDTH'(PROG_BASE)
                                 + ADDR_WIDTH'(cur_prog) * ADDR_WIDTH'(REGION_SIZE);
            default: region_base = ADDR_WIDTH'(OS_BASE);
        endcase
        rom_addr = region_base + ADDR_WIDTH'(pc);
    end

    assign cur_mode = state;

`ifdef SCHED_STATS_EN
    // -----------------------------------------------------------------------
    // Per-program issue statistics. A valid word seen while in S_PROG always
    // belongs to cur_prog: any program change squashes the in-flight word.
    // -----------------------------------------------------------------------
    logic [31:0] issued [NUM_PROGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PROGS; i++) begin
                issued[i] <= '0;
            end
        end else if (instr_valid && (state == S_PROG) && (issued[cur_prog] != '1)) begin
            issued[cur_prog] <= issued[cur_prog] + 32'd1;
        end
    end

    always_comb begin
        issued_count = '0;
        for (int i = 0; i < NUM_PROGS; i++) begin
            issued_count[i*32 +: 32] = issued[i];
        end
    end
`endif

endmodule

// File: tb/tb_rom_fetch_scheduler.sv
// ---------------------------------------------------------------------------
// tb_rom_fetch_scheduler
//   Self-checking bench for rom_fetch_scheduler (NUM_PROGS=2, QUANTUM=4).
//   A directed scenario walks through dispatch, preemption, branching,
//   stalls, halts and reset, then randomized traffic runs against a
//   behavioural model of the scheduler kept in plain integers.
// ---------------------------------------------------------------------------
module tb_rom_fetch_scheduler;

    localparam int NP      = 2;
    localparam int QUANTUM = 4;
    localparam int REGION  = 200;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        branch_valid;
    logic [7:0]  branch_target;
    logic        halt;
    logic        yield;
    logic        ctx_done;
    logic [31:0] rom_addr;
    logic        instr_valid;
    logic [1:0]  cur_mode;
    logic [0:0]  cur_prog;
    logic        ctx_switch;
    logic        all_done;
`ifdef SCHED_STATS_EN
    logic [NP*32-1:0] issued_count;
`endif

    rom_fetch_scheduler #(
        .NUM_PROGS (NP),
        .QUANTUM   (QUANTUM)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .halt          (halt),
        .yield         (yield),
        .ctx_done      (ctx_done),
        .rom_addr      (rom_addr),
        .instr_valid   (instr_valid),
        .cur_mode      (cur_mode),
        .cur_prog      (cur_prog),
        .ctx_switch    (ctx_switch),
        .all_done      (all_done)
`ifdef SCHED_STATS_EN
        ,
        .issued_count  (issued_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Checking
    // -----------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model. Modes: 0 idle, 1 routine, 2 OS, 3 user program.
    // -----------------------------------------------------------------------
    int m_mode;
    int m_pc;
    int m_cur;
    int m_q;
    int m_saved [NP];
    bit m_halted [NP];
    bit m_valid;
    bit m_ctx;
    bit m_done;

    function automatic int model_addr();
        case (m_mode)
            1:       return m_pc;
            3:       return 400 + m_cur * REGION + m_pc;
            default: return 200 + m_pc;
        endcase
    endfunction

    task automatic model_reset();
        m_mode  = 2;
        m_pc    = 0;
        m_cur   = 0;
        m_q     = 0;
        m_valid = 0;
        m_ctx   = 0;
        m_done  = 0;
        for (int i = 0; i < NP; i++) begin
            m_saved[i]  = 0;
            m_halted[i] = 0;
        end
    endtask

    task automatic model_step(input bit en, input bit br, input int tgt,
                              input bit ht, input bit yl, input bit cd);
        int  next_pc;
        int  p;
        bit  found;
        m_valid = 0;
        m_ctx   = 0;
        next_pc = en ? (m_pc + 1) % REGION : m_pc;
        case (m_mode)
            2: begin
                if (yl) begin
                    found = 0;
                    for (int k = 1; k <= NP; k++) begin
                        p = (m_cur + k) % NP;
                        if (!found && !m_halted[p]) begin
                            found = 1;
                            m_cur = p;
                        end
                    end
                    if (found) begin
                        m_mode = 3;
                        m_pc   = m_saved[m_cur];
                        m_q    = 0;
                    end else begin
                        m_mode = 0;
                        m_pc   = 0;
                        m_done = 1;
                    end
                end else begin
                    m_pc    = next_pc;
                    m_valid = en;
                end
            end
            3: begin
                if (br) next_pc = tgt;
                if (ht || (en && m_q == QUANTUM - 1)) begin
                    m_saved[m_cur] = next_pc;
                    if (ht) m_halted[m_cur] = 1;
                    m_mode = 1;
                    m_pc   = 0;
                    m_q    = 0;
                    m_ctx  = 1;
                end else begin
                    m_pc    = next_pc;
                    m_valid = en && !br;
                    if (en) m_q++;
                end
            end
            1: begin
                if (cd) begin
                    m_mode = 2;
                    m_pc   = 0;
                end else begin
                    m_pc    = next_pc;
                    m_valid = en;
                end
            end
            default: m_pc = 0;
        endcase
    endtask

    task automatic compare_all();
        check("rom_addr",    rom_addr,               32'(model_addr()));
        check("instr_valid", 32'(instr_valid),       32'(m_valid));
        check("cur_mode",    32'(cur_mode),          32'(m_mode));
        check("cur_prog",    32'(cur_prog),          32'(m_cur));
        check("ctx_switch",  32'(ctx_switch),        32'(m_ctx));
        check("all_done",    32'(all_done),          32'(m_done));
    endtask

    // One clock cycle. Entered and left at a falling edge: outputs are
    // compared, inputs driven, and the model advanced to the post-edge state.
    task automatic step(input bit en, input bit br = 0, input int tgt = 0,
                        input bit ht = 0, input bit yl = 0, input bit cd = 0);
        compare_all();
        enable        = en;
        branch_valid  = br;
        branch_target = 8'(tgt);
        halt          = ht;
        yield         = yl;
        ctx_done      = cd;
        model_step(en, br, tgt, ht, yl, cd);
        @(negedge clk);
    endtask

    // Asynchronous reset applied between edges; outputs must change at once.
    task automatic do_reset(input string tag);
        enable        = 0;
        branch_valid  = 0;
        branch_target = '0;
        halt          = 0;
        yield         = 0;
        ctx_done      = 0;
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_addr"},  rom_addr,          32'd200);
        check({tag, "_ctxsw"}, 32'(ctx_switch),   32'd0);
        check({tag, "_valid"}, 32'(instr_valid),  32'd0);
        check({tag, "_mode"},  32'(cur_mode),     32'd2);
        check({tag, "_done"},  32'(all_done),     32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        rst_n         = 1'b0;
        enable        = 0;
        branch_valid  = 0;
        branch_target = '0;
        halt          = 0;
        yield         = 0;
        ctx_done      = 0;
        model_reset();
        @(negedge clk);
        do_reset("por");

        // OS fetch from 200 upward, then yield dispatches program 1.
        repeat (3) step(1);
        check("os_offset3", rom_addr, 32'd203);
        step(1, 0, 0, 0, 1);
        check("p1_start", rom_addr, 32'd600);
        check("p1_start_squash", 32'(instr_valid), 32'd0);
        repeat (4) step(1);
        check("q_expire_mode", 32'(cur_mode), 32'd1);
        check("q_expire_addr", rom_addr, 32'd0);
        check("q_expire_pulse", 32'(ctx_switch), 32'd1);

        // Program 0 dispatch and a stalled branch at 402 -> 410.
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        check("p0_start", rom_addr, 32'd400);
        repeat (2) step(1);
        check("p0_pre_branch", rom_addr, 32'd402);
        step(0, 1, 10);
        check("branch_addr", rom_addr, 32'd410);
        check("branch_squash", 32'(instr_valid), 32'd0);
        step(1);
        check("branch_resume_valid", 32'(instr_valid), 32'd1);
        step(1);

        // Program 1 resumes at 604; a 5-cycle stall keeps the slice at 4.
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("p1_resume", rom_addr, 32'd604);
        step(1);
        repeat (5) step(0);
        check("stall_addr", rom_addr, 32'd605);
        check("stall_valid", 32'(instr_valid), 32'd0);
        repeat (3) step(1);
        check("stall_slice_end", 32'(cur_mode), 32'd1);

        // Halt with coincident expiry on program 0.
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        repeat (3) step(1);
        step(1, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        check("only_p1_a", 32'(cur_prog), 32'd1);
        repeat (4) step(1);
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        check("only_p1_b", rom_addr, 32'd612);
        step(1, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        check("idle_mode", 32'(cur_mode), 32'd0);
        check("idle_done", 32'(all_done), 32'd1);
        check("idle_addr", rom_addr, 32'd200);
        step(1, 1, 5, 1, 1, 1);
        step(1);

        // Reset in the middle of the switch routine clears the saved PCs.
        do_reset("idle_exit");
        step(1, 0, 0, 0, 1);
        repeat (4) step(1);
        check("pre_rst_ctx", 32'(cur_mode), 32'd1);
        do_reset("mid_ctx");
        step(1, 0, 0, 0, 1);
        check("saved_cleared", rom_addr, 32'd600);

        // Randomized traffic against the model.
        for (int phase = 0; phase < 3; phase++) begin
            do_reset("rnd");
            for (int n = 0; n < 500; n++) begin
                step($urandom_range(0, 9) < 8,
                     $urandom_range(0, 19) == 0,
                     int'($urandom_range(0, REGION - 1)),
                     $urandom_range(0, 39) == 0,
                     $urandom_range(0, 4) == 0,
                     $urandom_range(0, 3) == 0);
            end
        end
        compare_all();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
